// File: rtl/slc3_param_test_memory.sv
// ---------------------------------------------------------------------------
// slc3_param_test_memory
//
// Clocked, byte-lane SRAM behavioural model on a shared tristate data bus,
// used beside the slc3 core in the top-level bench. Word width, depth and
// read latency are parameters. A read-ready flag and saturating access
// counters let a bench watch bus traffic without probing internals.
//
// Parameters
//   DATA_W         data word width (even); upper lane is [DATA_W-1:DATA_W/2]
//   ADDR_W         address bus width
//   DEPTH          words stored (power of two, <= 2**ADDR_W)
//   READ_LAT       read latency in clocks, 1..4
//   CLEAR_ON_RESET 1: Reset zeroes every word; 0: contents retained
//
// Ports
//   Clk     in     system clock, rising edge
//   Reset   in     asynchronous, active-high reset
//   I_O     inout  bidirectional data bus (driven only for a ready read)
//   A       in     word address (index = A mod DEPTH)
//   CE      in     chip enable, active low
//   UB/LB   in     upper/lower lane enables, active low
//   OE      in     output enable, active low
//   WE      in     write enable, active low (overrides OE)
//   Rdy     out    read data valid on I_O (gated by the live request)
//   Rd_cnt  out    completed reads, saturating at 0xFFFF
//   Wr_cnt  out    performed writes, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module slc3_param_test_memory #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 20,
  parameter int DEPTH          = 1024,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  inout  wire  [DATA_W-1:0] I_O,
  input  logic [ADDR_W-1:0] A,
  input  logic              CE,
  input  logic              UB,
  input  logic              LB,
  input  logic              OE,
  input  logic              WE,
  output logic              Rdy,
  output logic [15:0]       Rd_cnt,
  output logic [15:0]       Wr_cnt
);

  localparam int HALF  = DATA_W / 2;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counter value at which the WAIT state hands over to VALID.
  localparam logic [1:0] LAST_CNT = 2'(READ_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [1:0]        lat_cnt;
  logic [1:0]        lat_cnt_next;
  logic [1:0]        cnt_inc;
  logic              capture;
  logic              load;

  logic [ADDR_W-1:0] cap_addr;
  logic              cap_ub;
  logic              cap_lb;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              rd_req;
  logic              same_req;
  logic              wr_en;
  logic              wr_any;
  logic [DATA_W-1:0] wmask;
  logic              drive_hi;
  logic              drive_lo;

  // Increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Bit mask of the lanes selected by the active-low lane enables.
  function automatic logic [DATA_W-1:0] lane_mask(input logic ub, input logic lb);
    return {{HALF{~ub}}, {HALF{~lb}}};
  endfunction

  // Decode the pin-level request/write conditions.
  always_comb begin
    idx      = A[IDX_W-1:0];
    wr_en    = ~CE & ~WE;
    wr_any   = wr_en & ~(UB & LB);
    wmask    = lane_mask(UB, LB);
    rd_req   = ~CE & WE & ~OE & ~(UB & LB);
    // The request being served is still the one that was captured.
    same_req = rd_req & (A == cap_addr) & (UB == cap_ub) & (LB == cap_lb);
  end

  // FSM state register and latency counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      lat_cnt <= 2'd0;
    end else begin
      state   <= next_state;
      lat_cnt <= lat_cnt_next;
    end
  end

  // FSM next-state logic: capture, latency count, load and abort.
  always_comb begin
    next_state   = state;
    lat_cnt_next = lat_cnt;
    capture      = 1'b0;
    load         = 1'b0;
    cnt_inc      = lat_cnt + 2'd1;
    case (state)
      ST_IDLE: begin
        if (rd_req) begin
          capture      = 1'b1;
          lat_cnt_next = 2'd0;
          if (READ_LAT == 1) begin
            next_state = ST_VALID;
            load       = 1'b1;
          end else begin
            next_state = ST_WAIT;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!same_req) begin
          // Aborted: the next sampled request starts the count afresh.
          next_state   = ST_IDLE;
          lat_cnt_next = 2'd0;
        end else if (cnt_inc == LAST_CNT) begin
          next_state   = ST_VALID;
          load         = 1'b1;
          lat_cnt_next = 2'd0;
        end else begin
          lat_cnt_next = cnt_inc;
        end
      end
      ST_VALID: begin
        if (!same_req) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_VALID;
        end
      end
      default: begin
        next_state   = ST_IDLE;
        lat_cnt_next = 2'd0;
      end
    endcase
  end

  // FSM outputs: Rdy and lane drives fall in the same cycle the request drops.
  always_comb begin
    Rdy      = (state == ST_VALID) & same_req;
    drive_hi = Rdy & ~UB;
    drive_lo = Rdy & ~LB;
  end

  // Capture of the address and lane enables of the request being served.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cap_addr <= '0;
      cap_ub   <= 1'b1;
      cap_lb   <= 1'b1;
    end else if (capture) begin
      cap_addr <= A;
      cap_ub   <= UB;
      cap_lb   <= LB;
    end else begin
      cap_addr <= cap_addr;
      cap_ub   <= cap_ub;
      cap_lb   <= cap_lb;
    end
  end

  // Read data register, loaded on entry into VALID.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dout <= '0;
    end else if (load) begin
      dout <= mem[idx];
    end else begin
      dout <= dout;
    end
  end

  // Saturating read/write counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Rd_cnt <= 16'd0;
      Wr_cnt <= 16'd0;
    end else begin
      Rd_cnt <= load   ? sat_inc(Rd_cnt) : Rd_cnt;
      Wr_cnt <= wr_any ? sat_inc(Wr_cnt) : Wr_cnt;
    end
  end

  generate
    if (CLEAR_ON_RESET != 0) begin : g_mem_clear
      // Storage array, zeroed by Reset; lane-masked write.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
          end
        end else if (wr_en) begin
          mem[idx] <= (mem[idx] & ~wmask) | (I_O & wmask);
        end else begin
          mem[idx] <= mem[idx];
        end
      end
    end else begin : g_mem_keep
      // Storage array, retained across Reset; writes blocked during Reset.
      always_ff @(posedge Clk) begin
        if (wr_en && !Reset) begin
          mem[idx] <= (mem[idx] & ~wmask) | (I_O & wmask);
        end else begin
          mem[idx] <= mem[idx];
        end
      end
    end
  endgenerate

  assign I_O[DATA_W-1:HALF] = drive_hi ? dout[DATA_W-1:HALF] : {HALF{1'bz}};
  assign I_O[HALF-1:0]      = drive_lo ? dout[HALF-1:0]      : {HALF{1'bz}};

endmodule

// File: doc/slc3_param_test_memory.md
# slc3_param_test_memory

Parametrised successor to the SLC-3 bench memory model: a clocked, byte-lane SRAM behavioural model on a shared tristate data bus. It sits beside the `slc3` core in the top-level bench and connects through the SRAM pins (`I_O`, `A`, `CE`, `UB`, `LB`, `OE`, `WE`). Word width, depth and read latency are configurable. It adds a read-ready flag and saturating access counters so benches can check bus traffic without probing internals.

## Interface
- `DATA_W`, 16: data word width; must be even; upper lane is bits [DATA_W-1:DATA_W/2].
- `ADDR_W`, 20: address bus width.
- `DEPTH`, 1024: words stored; power of two, ≤ 2^ADDR_W.
- `READ_LAT`, 1: read latency in clocks, 1..4.
- `CLEAR_ON_RESET`, 1: when 1, Reset zeroes all contents.
- `Clk`  in  1  system clock, rising-edge active.
- `Reset`  in  1  asynchronous, active-high reset.
- `I_O`  inout  DATA_W  bidirectional data bus.
- `A`  in  ADDR_W  word address.
- `CE`, `UB`, `LB`, `OE`, `WE`  in  1 each  chip enable, upper/lower lane enables, output enable, write enable; all active-low.
- `Rdy`  out  1  read data valid on `I_O`.
- `Rd_cnt`  out  16  completed reads, saturating.
- `Wr_cnt`  out  16  performed writes, saturating.

## Operation
- Index = `A` mod `DEPTH`; upper address bits are ignored, so addresses wrap.
- Write:
  - Occurs on a rising `Clk` with `CE`=0 and `WE`=0.
  - `UB`=0 writes the upper lane from `I_O`; `LB`=0 writes the lower lane. A lane with its enable high keeps its old value.
  - `Wr_cnt` increments when at least one lane is written.
  - `WE`=0 overrides `OE`; the model never drives `I_O` while `WE`=0.
- Read request: `CE`=0, `WE`=1, `OE`=0, with at least one lane enabled.
- State machine: IDLE, WAIT, VALID. A 2-bit latency counter runs in WAIT.
  - IDLE → WAIT when a request is sampled; the index and lane enables are captured. If `READ_LAT`=1, go directly IDLE → VALID.
  - WAIT: the counter counts up. Reaching `READ_LAT`-1 loads the data register from memory and moves to VALID.
  - VALID: `Rdy`=1. Leave VALID for IDLE when the request drops, `A` changes, `UB`/`LB` change, or a write occurs.
  - WAIT → IDLE under the same conditions. No data is loaded, and the next edge with a valid request restarts the latency count.
  - `Rd_cnt` increments once on each entry into VALID.
- Bus drive (combinational):
  - In VALID with the request still asserted, the upper lane drives data when `UB`=0 and the lower lane when `LB`=0.
  - Any disabled lane, and any other case, is Z.
- Read-after-write, same index: a read whose request is first sampled at the edge after the write returns the new data. A write always forces IDLE first.
- Counters stay at 0xFFFF once reached.
- Reset (asynchronous):
  - State → IDLE; `Rdy`=0; `Rd_cnt`=`Wr_cnt`=0; data register =0; `I_O`=Z.
  - With `CLEAR_ON_RESET`=1 every word is 0 after reset; with 0, contents are retained.
  - Writes are blocked while `Reset`=1.
  - Reset during WAIT or VALID aborts the read without incrementing `Rd_cnt`.

## Timing
- Write commits at the rising edge where `CE`=`WE`=0; there is no write latency.
- A read request first sampled at edge t0 gives `Rdy`=1 and valid `I_O` after edge t0+`READ_LAT`-1, held until the request changes.
- Release: `I_O` goes Z and `Rdy` goes 0 in the same cycle that `OE`, `CE` or `WE` deasserts the request (`Rdy` combinationally gated). The state register updates at the next edge.
- No combinational path exists from `I_O` to `Rdy` or the counters.

## Test plan
- Reset with `CLEAR_ON_RESET`=1, then read 0x00000 at `READ_LAT`=1 → `Rdy`=1 after the first edge, `I_O`=0x0000, `Rd_cnt`=1, `Wr_cnt`=0.
- Byte lanes: write 0xABCD to 0x10 with `UB`=`LB`=0, then write 0x1234 with `UB`=1, `LB`=0, then read → 0xAB34. A read with `LB`=1 shows the lower lane as Z.
- `READ_LAT`=3: request at edge t0 → `Rdy`=0 after t0 and t0+1, `Rdy`=1 after t0+2. Changing `A` at t0+1 restarts the count and `Rd_cnt` does not increment for the aborted read.
- Wrap with `DEPTH`=1024: write 0x5555 to 0x00400, then read 0x00000 → 0x5555.
- Contention: `WE`=0 and `OE`=0 together → `I_O` stays Z from the model and the write commits; an in-progress VALID read drops to IDLE.
- Reset asserted mid-WAIT → `Rdy`=0, `I_O`=Z and counters 0 immediately, without waiting for a clock edge. Preload 0xFFFF writes → `Wr_cnt` saturates at 0xFFFF.
